dl_sequencer: RTL

- Sequences the HPS ioctl download stream for the arcade core.
- Routes ROM bytes (index ROM_INDEX) to four ROM regions through one-hot write strobes with region-relative addresses.
- Latches DIP bytes (index DIP_INDEX) into an 8-byte bank.
- Holds the game core in reset while ROMs load, then for a settle period; flags incomplete or oversize downloads.

---
 rtl/dl_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/dl_sequencer.sv
// dl_sequencer: steers the HPS ioctl download stream into four ROM regions,
// captures the DIP switch bytes, and holds the game core in reset until a
// complete ROM image has landed and a settle period has elapsed.
//
// Handshake: ioctl_wr is a single-cycle valid with no ready/back-pressure;
// every strobe is either consumed or discarded in the cycle it is sampled,
// and each accepted ROM byte yields exactly one rom_we pulse one cycle later.
module dl_sequencer #(
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter logic [7:0]  DIP_INDEX   = 8'd254,
  parameter logic [24:0] END0        = 25'h04000,
  parameter logic [24:0] END1        = 25'h05000,
  parameter logic [24:0] END2        = 25'h07000,
  parameter logic [24:0] END3        = 25'h0B000,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic [3:0]  rom_we,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [63:0] dip_bank,
  output logic        core_reset,
  output logic        dl_busy,
  output logic        dl_error,
  output logic [24:0] byte_count
);

  localparam int CW = $clog2(HOLD_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_hold;
  logic          r_dl_old;
  logic          r_core_reset;
  logic          r_dl_busy;
  logic          r_dl_error;
  logic [24:0]   r_byte_count;
  logic [3:0]    r_rom_we;
  logic [15:0]   r_rom_addr;
  logic [7:0]    r_rom_data;
  logic [63:0]   r_dip_bank;

  logic          w_dl_rise;
  logic          w_dl_fall;
  logic          w_rom_idx;
  logic          w_rom_rise;
  logic          w_rom_acc;
  logic          w_in_range;
  logic          w_rom_take;
  logic          w_good_end;
  logic          w_bad_end;
  logic          w_dip_wr;
  logic [3:0]    w_region;
  logic [15:0]   w_base;
  logic [15:0]   w_rel_addr;

  assign w_dl_rise  = ioctl_download & ~r_dl_old;
  assign w_dl_fall  = ~ioctl_download & r_dl_old;
  assign w_rom_idx  = (ioctl_index == ROM_INDEX);
  assign w_rom_rise = w_dl_rise & w_rom_idx;
  assign w_rom_acc  = ioctl_wr & w_rom_idx & ((r_state == S_LOAD) | w_rom_rise);
  assign w_in_range = (ioctl_addr < END3);
  assign w_rom_take = w_rom_acc & w_in_range;
  assign w_good_end = (r_byte_count == END3) & ~r_dl_error;
  assign w_bad_end  = (r_state == S_LOAD) & w_dl_fall & ~w_good_end;
  assign w_dip_wr   = ioctl_wr & (ioctl_index == DIP_INDEX) & (ioctl_addr[24:3] == 22'd0);
  // Only the low 16 bits of the offset are kept, so the low bits suffice.
  assign w_rel_addr = ioctl_addr[15:0] - w_base;

  // Priority region decode: lowest region whose end is above the address.
  always_comb begin
    w_region = 4'b0000;
    w_base   = 16'h0000;
    if (ioctl_addr < END0) begin
      w_region = 4'b0001;
      w_base   = 16'h0000;
    end else if (ioctl_addr < END1) begin
      w_region = 4'b0010;
      w_base   = END0[15:0];
    end else if (ioctl_addr < END2) begin
      w_region = 4'b0100;
      w_base   = END1[15:0];
    end else if (ioctl_addr < END3) begin
      w_region = 4'b1000;
      w_base   = END2[15:0];
    end
  end

  // Download edge history. It follows the line even through reset so that a
  // download already in flight when reset lifts is not mistaken for a new one.
  always_ff @(posedge clk_sys) begin
    r_dl_old <= ioctl_download;
  end

  // Sequencer FSM with its registered status outputs and byte accounting.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_core_reset <= 1'b1;
      r_dl_busy    <= 1'b0;
      r_dl_error   <= 1'b0;
      r_byte_count <= 25'd0;
    end else begin
      if (w_rom_rise) begin
        r_state      <= S_LOAD;
        r_core_reset <= 1'b1;
        r_dl_busy    <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_core_reset <= 1'b1;
            r_dl_busy    <= 1'b0;
          end
          S_LOAD: begin
            r_core_reset <= 1'b1;
            if (w_dl_fall) begin
              r_dl_busy <= 1'b0;
              if (w_good_end) begin
                r_state <= S_SETTLE;
                r_hold  <= CW'(HOLD_CYCLES - 1);
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
          S_SETTLE: begin
            r_core_reset <= 1'b1;
            r_dl_busy    <= 1'b0;
            if (r_hold == '0) begin
              r_state      <= S_RUN;
              r_core_reset <= 1'b0;
            end else begin
              r_hold <= r_hold - 1'b1;
            end
          end
          default: begin
            r_core_reset <= 1'b0;
            r_dl_busy    <= 1'b0;
          end
        endcase
      end

      // A new ROM download wipes the old error, but an oversize byte in the
      // very same cycle still counts against the new download.
      r_dl_error <= (w_rom_acc & ~w_in_range) | w_bad_end | (r_dl_error & ~w_rom_rise);

      if (w_rom_rise) begin
        r_byte_count <= {24'd0, w_rom_take};
      end else if (w_rom_take) begin
        r_byte_count <= r_byte_count + 25'd1;
      end
    end
  end

  // ROM write port: one-cycle strobe; address and data hold between strobes.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_rom_we   <= 4'b0000;
      r_rom_addr <= 16'h0000;
      r_rom_data <= 8'h00;
    end else begin
      r_rom_we <= w_rom_take ? w_region : 4'b0000;
      if (w_rom_take) begin
        r_rom_addr <= w_rel_addr;
        r_rom_data <= ioctl_dout;
      end
    end
  end

  // DIP bank capture, independent of the sequencer state.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_dip_bank <= 64'h0;
    end else if (w_dip_wr) begin
      r_dip_bank[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
    end
  end

  assign rom_we     = r_rom_we;
  assign rom_addr   = r_rom_addr;
  assign rom_data   = r_rom_data;
  assign dip_bank   = r_dip_bank;
  assign core_reset = r_core_reset;
  assign dl_busy    = r_dl_busy;
  assign dl_error   = r_dl_error;
  assign byte_count = r_byte_count;

endmodule
